// File: rtl/filter_lcd_pkg.sv
// filter_lcd_pkg: filter encoding, HD44780 command bytes and the line-1 text ROM
package filter_lcd_pkg;
  typedef enum logic [1:0] {NONE, BLUR, EDGE, GREY} filter_t;
  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] LINE1    = 8'h80;
  function automatic logic [7:0] init_cmd(logic [1:0] i);
    return i == 2'd0 ? FUNC_SET : i == 2'd1 ? DISP_ON : i == 2'd2 ? CLEAR : ENTRY;
  endfunction
  function automatic logic [7:0] text_char(filter_t f, logic [3:0] i);
    logic [31:0] name;
    logic [127:0] line;
    int k;
    name = f == NONE ? "NONE" : f == BLUR ? "BLUR" : f == EDGE ? "EDGE" : "GREY";
    line = {"FILTER: ", name, "    "};
    k = int'(i);
    return line[8*(15-k) +: 8];
  endfunction
endpackage

// File: rtl/filter_select_lcd_debounce.sv
// key_debounce: clk/reset/key in, press = one-cycle pulse once key is stable high
module key_debounce import filter_lcd_pkg::*; #(
  parameter int DELAY_COUNTS = 2500
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DELAY_COUNTS + 1);
  logic k_q, lvl, hit;
  logic [CW-1:0] cnt;
  assign hit = k_q && cnt == CW'(DELAY_COUNTS);
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q   <= 1'b0;
      cnt   <= '0;
      lvl   <= 1'b0;
      press <= 1'b0;
    end else begin
      k_q   <= key;
      cnt   <= !k_q ? '0 : hit ? cnt : cnt + 1'b1;
      lvl   <= hit;
      press <= hit && !lvl;
    end
  end
endmodule

// File: rtl/filter_select_lcd.sv
// filter_select_lcd: keys -> filter_type, and LCD_* pins show the selected filter name
module filter_select_lcd import filter_lcd_pkg::*; #(
  parameter int DELAY_COUNTS = 2500,
  parameter int EN_CYCLES    = 16,
  parameter int CMD_WAIT     = 2500,
  parameter int CLEAR_WAIT   = 100000,
  parameter int POWERUP_WAIT = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  output logic [1:0] filter_type,
  output logic [7:0] LCD_DATA,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW
);
  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETADDR, CHARS} state_t;
  typedef enum logic [1:0] {SETUP, STROBE, HOLD} phase_t;
  state_t state, state_n;
  phase_t ph, ph_n;
  filter_t shown, shown_n;
  logic [31:0] cnt, cnt_n, wait_last;
  logic [3:0] idx, idx_n, press;
  logic [1:0] sel;
  logic [7:0] cur_byte;
  logic pend, pend_n, writing, byte_done;
  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DELAY_COUNTS(DELAY_COUNTS)) u_db (.clk(clk), .reset(reset), .key(key[i]), .press(press[i]));
  end
  assign sel = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : press[3] ? 2'd3 : filter_type;
  always_comb begin
    writing   = state == INIT || state == SETADDR || state == CHARS;
    cur_byte  = state == INIT ? init_cmd(idx[1:0]) : state == SETADDR ? LINE1 :
                state == CHARS ? text_char(shown, idx) : 8'h00;
    wait_last = state == INIT && cur_byte == CLEAR ? 32'(CLEAR_WAIT - 1) : 32'(CMD_WAIT - 1);
    byte_done = writing && ph == HOLD && cnt == wait_last;
    state_n   = state;
    ph_n      = ph;
    cnt_n     = cnt + 1;
    idx_n     = idx;
    shown_n   = shown;
    pend_n    = pend;
    if (state == PWRUP) begin
      if (cnt == 32'(POWERUP_WAIT - 1)) begin
        state_n = INIT;
        ph_n    = SETUP;
        cnt_n   = '0;
        idx_n   = '0;
      end
    end else if (state == IDLE) begin
      cnt_n = '0;
      if (pend || shown != filter_t'(filter_type)) begin
        state_n = SETADDR;
        ph_n    = SETUP;
        shown_n = filter_t'(filter_type);
        pend_n  = 1'b0;
        idx_n   = '0;
      end
    end else if (ph == SETUP) begin
      ph_n  = STROBE;
      cnt_n = '0;
    end else if (ph == STROBE) begin
      if (cnt == 32'(EN_CYCLES - 1)) begin
        ph_n  = HOLD;
        cnt_n = '0;
      end
    end else if (byte_done) begin
      ph_n  = SETUP;
      cnt_n = '0;
      idx_n = idx + 1'b1;
      if (state == INIT && idx == 4'd3) begin
        state_n = IDLE;
        pend_n  = 1'b1;
      end
      if (state == SETADDR) begin
        state_n = CHARS;
        idx_n   = '0;
      end
      if (state == CHARS && idx == 4'd15) state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PWRUP;
      ph          <= SETUP;
      cnt         <= '0;
      idx         <= '0;
      shown       <= NONE;
      pend        <= 1'b0;
      filter_type <= 2'd0;
    end else begin
      state       <= state_n;
      ph          <= ph_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shown       <= shown_n;
      pend        <= pend_n;
      filter_type <= sel;
    end
  end
  assign LCD_EN   = writing && ph == STROBE;
  assign LCD_RS   = state == CHARS;
  assign LCD_DATA = cur_byte;
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;
endmodule

// File: tb/tb_filter_select_lcd.sv
// tb_filter_select_lcd: directed bench for filter_select_lcd with small timing parameters
module tb_filter_select_lcd;
  localparam int DC = 2, EC = 2, CW = 4, CLW = 8, PW = 10;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] key = 4'b0000;
  logic [1:0] filter_type;
  logic [7:0] LCD_DATA;
  logic LCD_ON, LCD_BLON, LCD_EN, LCD_RS, LCD_RW;
  int compared = 0, mism = 0;
  int n, highs;

  filter_select_lcd #(
    .DELAY_COUNTS(DC), .EN_CYCLES(EC), .CMD_WAIT(CW), .CLEAR_WAIT(CLW), .POWERUP_WAIT(PW)
  ) dut (
    .clk(clk), .reset(reset), .key(key), .filter_type(filter_type), .LCD_DATA(LCD_DATA),
    .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_byte(input logic rs, input logic [7:0] d, input string tag, output int waited);
    logic [7:0] prev;
    logic held;
    int w;
    waited = 0;
    prev = LCD_DATA;
    while (LCD_EN !== 1'b1 && waited < 400) begin
      prev = LCD_DATA;
      tick();
      waited++;
    end
    check($sformatf("%s_en_seen", tag), LCD_EN, 1);
    check($sformatf("%s_data", tag), LCD_DATA, d);
    check($sformatf("%s_rs", tag), LCD_RS, rs);
    check($sformatf("%s_setup", tag), prev, d);
    w = 0;
    held = 1'b1;
    while (LCD_EN === 1'b1 && w < 50) begin
      held &= (LCD_DATA === d && LCD_RS === rs);
      tick();
      w++;
    end
    check($sformatf("%s_en_width", tag), w, EC);
    check($sformatf("%s_stable", tag), held, 1);
    check($sformatf("%s_hold", tag), LCD_DATA, d);
  endtask

  task automatic chars(input string t, input string tag);
    int dummy;
    logic [7:0] c;
    for (int i = 0; i < 16; i++) begin
      c = t[i];
      wait_byte(1'b1, c, $sformatf("%s_c%0d", tag, i), dummy);
    end
  endtask

  task automatic find_byte(input logic [7:0] d, input string tag);
    int k = 0;
    while (!(LCD_EN === 1'b1 && LCD_DATA === d && LCD_RS === 1'b0) && k < 400) begin
      tick();
      k++;
    end
    check($sformatf("%s_found", tag), LCD_EN === 1'b1 && LCD_DATA === d, 1);
    k = 0;
    while (LCD_EN === 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check($sformatf("%s_en_width", tag), k, EC);
  endtask

  task automatic press(input logic [3:0] k);
    key = k;
    repeat (4) tick();
    key = 4'b0000;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_ft", filter_type, 0);
    check("rst_en", LCD_EN, 0);
    check("rst_rs", LCD_RS, 0);
    check("rst_data", LCD_DATA, 0);
    check("rst_rw", LCD_RW, 0);
    check("rst_on", LCD_ON, 1);
    check("rst_blon", LCD_BLON, 1);
    reset = 1'b0;
    wait_byte(1'b0, 8'h38, "init0", n);
    check("pwrup_delay", n, PW + 1);
    wait_byte(1'b0, 8'h0C, "init1", n);
    check("cmd_wait", n, CW + 1);
    wait_byte(1'b0, 8'h01, "init2", n);
    wait_byte(1'b0, 8'h06, "init3", n);
    check("clear_wait", n, CLW + 1);
    wait_byte(1'b0, 8'h80, "addr_none", n);
    chars("FILTER: NONE    ", "none");
    check("idle_ft", filter_type, 0);
    check("idle_on", LCD_ON & LCD_BLON, 1);
    key = 4'b0010;
    repeat (4) tick();
    check("ft_not_early", filter_type, 0);
    key = 4'b0000;
    tick();
    check("ft_blur", filter_type, 1);
    wait_byte(1'b0, 8'h80, "addr_blur", n);
    chars("FILTER: BLUR    ", "blur");
    press(4'b0100);
    check("ft_edge", filter_type, 2);
    repeat (25) tick();
    press(4'b1000);
    check("ft_grey", filter_type, 3);
    find_byte(8'h80, "addr_grey");
    chars("FILTER: GREY    ", "grey");
    highs = 0;
    repeat (60) begin
      tick();
      if (LCD_EN === 1'b1) highs++;
    end
    check("single_extra_refresh", highs, 0);
    key = 4'b0001;
    repeat (2) tick();
    key = 4'b0000;
    repeat (6) tick();
    check("glitch_ignored", filter_type, 3);
    press(4'b0011);
    check("low_index_wins", filter_type, 0);
    press(4'b0100);
    check("ft_edge2", filter_type, 2);
    n = 0;
    while (!(LCD_EN === 1'b1 && LCD_RS === 1'b1) && n < 400) begin
      tick();
      n++;
    end
    check("chars_strobe_seen", LCD_EN === 1'b1 && LCD_RS === 1'b1, 1);
    reset = 1'b1;
    tick();
    check("midrst_en", LCD_EN, 0);
    check("midrst_ft", filter_type, 0);
    check("midrst_rs", LCD_RS, 0);
    check("midrst_data", LCD_DATA, 0);
    check("midrst_on", LCD_ON & LCD_BLON, 1);
    reset = 1'b0;
    wait_byte(1'b0, 8'h38, "reinit0", n);
    check("repwrup_delay", n, PW + 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/filter_select_lcd.md
Name: filter_select_lcd

Overview:
Converts the four push-buttons into a 2-bit video filter selection and shows the selected filter's name on the HD44780-compatible 16x2 character LCD. It sits between the board keys and the video filter pipeline. filter_type feeds the pipeline, and the LCD_* pins go to the board.

Parameters:
DELAY_COUNTS, 2500, debounce stability count in clk cycles
EN_CYCLES, 16, LCD_EN high-pulse width in cycles
CMD_WAIT, 2500, idle cycles after each byte write (≥40 µs at 50 MHz)
CLEAR_WAIT, 100000, idle cycles after the clear command 0x01 (≥2 ms)
POWERUP_WAIT, 750000, cycles after reset before the first command (≥15 ms)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
key  in  4  raw push-buttons, 1 = pressed
filter_type  out  2  selected filter: 0 NONE, 1 BLUR, 2 EDGE, 3 GREY
LCD_DATA  out  8  LCD data bus
LCD_ON  out  1  LCD power
LCD_BLON  out  1  backlight
LCD_EN  out  1  LCD enable strobe
LCD_RS  out  1  0 = command, 1 = character
LCD_RW  out  1  read/write, tied 0

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high. Every register clears on the clk edge where reset = 1.
- Reset values:
  - filter_type = 0.
  - LCD_EN = 0, LCD_RS = 0, LCD_DATA = 0x00, LCD_RW = 0.
  - LCD_ON = 1 and LCD_BLON = 1 at all times, including during reset.
- Debounce (per key):
  - key[i] is registered once.
  - A counter counts consecutive edges on which the registered value is 1, and clears on any 0.
  - The debounced level goes high when the counter reaches DELAY_COUNTS.
  - A press pulse lasts one cycle, on the rising edge of the debounced level.
  - With DELAY_COUNTS=2, holding a key high for 4 edges produces the pulse, and filter_type updates on the following edge.
- Selection:
  - A press pulse on key[i] sets filter_type = i.
  - If several pulses occur in one cycle, the lowest index wins.
  - Releasing a key has no effect.
  - Pressing the key that is already selected leaves filter_type unchanged.
  - Holding a key produces only one pulse.
- LCD FSM states: PWRUP → INIT (0x38, 0x0C, 0x01, 0x06 in order) → IDLE → SETADDR (0x80) → CHARS (16 bytes) → IDLE.
  - PWRUP waits POWERUP_WAIT cycles.
  - IDLE starts a refresh when shown_type ≠ filter_type, or on the first entry after INIT.
  - At the start of SETADDR, filter_type is latched into shown_type.
  - A selection change during a refresh causes exactly one further refresh after the current one completes.
- Line-1 text, 16 ASCII characters, space-padded:
  - 0: "FILTER: NONE"
  - 1: "FILTER: BLUR"
  - 2: "FILTER: EDGE"
  - 3: "FILTER: GREY"
- Byte write timing:
  - Cycle 0: drive RS and DATA, EN = 0 (setup).
  - Next EN_CYCLES cycles: EN = 1.
  - Then EN = 0, with RS and DATA held.
  - Then wait CMD_WAIT cycles, or CLEAR_WAIT after 0x01.
  - The next byte starts only after the wait completes. There is no busy-flag polling.
- Reset mid-write returns the FSM to PWRUP, forces EN = 0 on that same edge, and resets filter_type to 0.

Decomposition:
- Package filter_lcd_pkg holds:
  - filter_t enum (NONE, BLUR, EDGE, GREY);
  - LCD command constants (FUNC_SET 0x38, DISP_ON 0x0C, CLEAR 0x01, ENTRY 0x06, LINE1 0x80);
  - a text-ROM function mapping filter_t and character index to an ASCII byte.
- One sub-module, key_debounce (parameter DELAY_COUNTS), instantiated four times.
- The LCD sequencing and byte-write timing stay in the top level.

Test Plan:
Bench parameters: DELAY_COUNTS=2, EN_CYCLES=2, CMD_WAIT=4, CLEAR_WAIT=8, POWERUP_WAIT=10.
1. Hold reset for 3 cycles then release → filter_type = 0, EN = 0, RW = 0, ON = BLON = 1; the first EN pulse appears after 10 cycles with DATA = 0x38 and RS = 0.
2. After INIT, with no presses → bytes 0x80 then "FILTER: NONE" plus 4 spaces (RS = 1) are written; each EN pulse is exactly 2 cycles, and DATA is stable from one cycle before EN rises until EN falls.
3. Key[1] high for 4 cycles then low → filter_type = 1 within 5 cycles; the LCD rewrites 0x80 followed by "FILTER: BLUR".
4. Key[2] pulse, then key[3] pulse, 300 ns apart → filter_type goes 2 then 3, with the final LCD text "FILTER: GREY".
5. A 2-cycle glitch on key[0], then key[0] and key[1] asserted together for 4 cycles → the glitch has no effect; filter_type = 0 (lowest index wins).
6. Assert reset during a CHARS write while EN = 1 → EN = 0 on the same edge; the FSM restarts from PWRUP with filter_type = 0.
